kettle_sensor_conditioner: RTL and testbench

KETTLE_SENSOR_CONDITIONER -- requirements
Module: kettle_sensor_conditioner

---
 rtl/kettle_sensor_conditioner.sv | 154 +++++++++++++++
 tb/tb_kettle_sensor_conditioner.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kettle_sensor_conditioner.sv
// Kettle sensor front end: synchronizes and debounces the start button and
// water-level switch, produces a gated one-cycle start request, averages the
// temperature over a 4-sample window with an over-temperature flag, and
// latches a sensor fault when temperature samples stop arriving.
module kettle_sensor_conditioner #(
  parameter int         DEBOUNCE_CYC   = 4,
  parameter logic [7:0] OVERTEMP_LIMIT = 8'd100,
  parameter int         TIMEOUT_CYC    = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  input  logic       water_raw,
  input  logic [7:0] temp_raw,
  input  logic       sample_valid,
  output logic       start_pulse,
  output logic       water_ok,
  output logic [7:0] temp_filt,
  output logic       temp_valid,
  output logic       over_temp,
  output logic       sensor_fault
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  // Bit 0 is the button, bit 1 the water switch.
  logic [1:0] raw_in;
  logic [1:0] db_level;

  assign raw_in = {water_raw, btn_raw};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_db
      logic            sync1_reg;
      logic            sync2_reg;
      logic            level_reg;
      logic [DB_W-1:0] cnt_reg;

      // Two-flop synchronizer for the asynchronous raw input.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync1_reg <= 1'b0;
          sync2_reg <= 1'b0;
        end else begin
          sync1_reg <= raw_in[gi];
          sync2_reg <= sync1_reg;
        end
      end

      // Adopt a new level only after DEBOUNCE_CYC consecutive differing cycles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          level_reg <= 1'b0;
          cnt_reg   <= '0;
        end else if (sync2_reg == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DB_W'(DEBOUNCE_CYC - 1)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + DB_W'(1);
        end
      end

      assign db_level[gi] = level_reg;
    end
  endgenerate

  logic btn_d_reg;
  logic fault_reg;

  // Remember the previous debounced button level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_d_reg <= 1'b0;
    end else begin
      btn_d_reg <= db_level[0];
    end
  end

  // A press that occurs without water or with a fault is simply dropped.
  assign start_pulse  = db_level[0] & ~btn_d_reg & db_level[1] & ~fault_reg;
  assign water_ok     = db_level[1];
  assign sensor_fault = fault_reg;

  logic [7:0] win_reg [0:3];
  logic [2:0] fill_reg;
  logic [9:0] sum_reg;
  logic       upd_reg;
  logic       full_reg;

  // Sample window shift with a running sum; entry 3 is the oldest sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        win_reg[i] <= 8'd0;
      end
      fill_reg <= 3'd0;
      sum_reg  <= 10'd0;
      upd_reg  <= 1'b0;
      full_reg <= 1'b0;
    end else if (sample_valid) begin
      win_reg[0] <= temp_raw;
      for (int i = 1; i < 4; i++) begin
        win_reg[i] <= win_reg[i-1];
      end
      sum_reg  <= sum_reg + {2'b00, temp_raw} - {2'b00, win_reg[3]};
      fill_reg <= (fill_reg == 3'd4) ? 3'd4 : fill_reg + 3'd1;
      upd_reg  <= 1'b1;
      full_reg <= (fill_reg >= 3'd3);
    end else begin
      upd_reg <= 1'b0;
    end
  end

  // Publish the average one edge after the sample; flag only full windows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      temp_filt  <= 8'd0;
      temp_valid <= 1'b0;
      over_temp  <= 1'b0;
    end else begin
      temp_valid <= upd_reg & full_reg;
      if (upd_reg) begin
        temp_filt <= sum_reg[9:2];
      end
      if (upd_reg && full_reg) begin
        over_temp <= (sum_reg[9:2] >= OVERTEMP_LIMIT);
      end
    end
  end

  logic [TO_W-1:0] idle_reg;

  // Count idle cycles; a sample on the limiting cycle wins over the fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_reg  <= '0;
      fault_reg <= 1'b0;
    end else if (sample_valid) begin
      idle_reg <= '0;
    end else begin
      if (idle_reg != TO_W'(TIMEOUT_CYC)) begin
        idle_reg <= idle_reg + TO_W'(1);
      end
      if (idle_reg == TO_W'(TIMEOUT_CYC - 1)) begin
        fault_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_kettle_sensor_conditioner.sv
// Testbench for kettle_sensor_conditioner: table-driven filter vectors,
// hand-written multi-cycle sequences and randomized stimulus, all checked
// against a behavioural model of the sensor conditioning rules.
module tb_kettle_sensor_conditioner;

  localparam int D   = 4;
  localparam int LIM = 100;
  localparam int TO  = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_raw = 1'b0;
  logic       water_raw = 1'b0;
  logic [7:0] temp_raw = 8'd0;
  logic       sample_valid = 1'b0;
  logic       start_pulse;
  logic       water_ok;
  logic [7:0] temp_filt;
  logic       temp_valid;
  logic       over_temp;
  logic       sensor_fault;

  kettle_sensor_conditioner #(
    .DEBOUNCE_CYC   (D),
    .OVERTEMP_LIMIT (8'd100),
    .TIMEOUT_CYC    (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_raw      (btn_raw),
    .water_raw    (water_raw),
    .temp_raw     (temp_raw),
    .sample_valid (sample_valid),
    .start_pulse  (start_pulse),
    .water_ok     (water_ok),
    .temp_filt    (temp_filt),
    .temp_valid   (temp_valid),
    .over_temp    (over_temp),
    .sensor_fault (sensor_fault)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit       btn_hist [0:8191];
  bit       wat_hist [0:8191];
  int       n;
  bit [1:0] mlvl;
  bit       mstart;
  int       idle;
  bit       mfault;
  int       mfilt;
  bit       mvalid;
  bit       mover;
  bit       pend;
  int       pend_avg;
  bit       pend_full;
  int       win[$];

  task automatic model_reset();
    n = 0; mlvl = 2'b00; mstart = 0; idle = 0; mfault = 0;
    mfilt = 0; mvalid = 0; mover = 0; pend = 0; pend_avg = 0; pend_full = 0;
    win.delete();
  endtask

  // Value the debouncer sees at edge e: the raw input two edges earlier.
  function automatic bit synced(input int w, input int e);
    if (e < 3) return 1'b0;
    return (w == 1) ? wat_hist[e-2] : btn_hist[e-2];
  endfunction

  task automatic model_edge();
    bit old_btn;
    bit adopt;
    int s;
    int dummy;
    n++;
    btn_hist[n] = btn_raw;
    wat_hist[n] = water_raw;
    old_btn = mlvl[0];
    for (int w = 0; w < 2; w++) begin
      adopt = 1;
      for (int j = 0; j < D; j++)
        if (n - j < 1 || synced(w, n - j) == mlvl[w]) adopt = 0;
      if (adopt) mlvl[w] = !mlvl[w];
    end
    if (sample_valid) idle = 0; else idle++;
    if (idle >= TO) mfault = 1;
    mstart = mlvl[0] && !old_btn && mlvl[1] && !mfault;
    if (pend) begin
      mfilt  = pend_avg;
      mvalid = pend_full;
      if (pend_full) mover = (pend_avg >= LIM);
    end else begin
      mvalid = 0;
    end
    if (sample_valid) begin
      win.push_back(int'(temp_raw));
      if (win.size() > 4) dummy = win.pop_front();
      s = 0;
      foreach (win[k]) s += win[k];
      pend = 1; pend_avg = s / 4; pend_full = (win.size() == 4);
    end else begin
      pend = 0;
    end
  endtask

  task automatic compare_all();
    check("water_ok", water_ok, mlvl[1]);
    check("start_pulse", start_pulse, mstart);
    check("temp_filt", temp_filt, mfilt);
    check("temp_valid", temp_valid, mvalid);
    check("over_temp", over_temp, mover);
    check("sensor_fault", sensor_fault, mfault);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_start"}, start_pulse, 0);
    check({tag, "_water"}, water_ok, 0);
    check({tag, "_filt"}, temp_filt, 0);
    check({tag, "_valid"}, temp_valid, 0);
    check({tag, "_over"}, over_temp, 0);
    check({tag, "_fault"}, sensor_fault, 0);
  endtask

  int pulses;

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
    if (start_pulse === 1'b1) pulses++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit sv;
    int temp;
    int filt;
    bit valid;
    bit over;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1, 100, 0,   0, 0};
    tbl[1]  = '{1, 104, 25,  0, 0};
    tbl[2]  = '{1, 108, 51,  0, 0};
    tbl[3]  = '{1, 112, 78,  0, 0};
    tbl[4]  = '{1, 0,   106, 1, 1};
    tbl[5]  = '{0, 0,   81,  1, 0};
    tbl[6]  = '{0, 0,   81,  0, 0};
    tbl[7]  = '{1, 255, 81,  0, 0};
    tbl[8]  = '{1, 255, 118, 1, 1};
    tbl[9]  = '{1, 255, 155, 1, 1};
    tbl[10] = '{1, 255, 191, 1, 1};
    tbl[11] = '{0, 0,   255, 1, 1};
    tbl[12] = '{1, 1,   255, 0, 1};
    tbl[13] = '{1, 1,   191, 1, 1};
    tbl[14] = '{1, 1,   128, 1, 1};
    tbl[15] = '{1, 2,   64,  1, 0};
    tbl[16] = '{0, 0,   1,   1, 0};
    tbl[17] = '{0, 0,   1,   0, 0};

    // Reset state
    do_reset();
    check_all_zero("reset");

    // Filter vectors: averaging, first-window suppression, 255 saturation, truncation
    for (int i = 0; i < 18; i++) begin
      sample_valid = tbl[i].sv;
      temp_raw = 8'(tbl[i].temp);
      step();
      check($sformatf("tbl%0d_filt", i), temp_filt, tbl[i].filt);
      check($sformatf("tbl%0d_valid", i), temp_valid, tbl[i].valid);
      check($sformatf("tbl%0d_over", i), over_temp, tbl[i].over);
    end

    // Asynchronous reset mid-run with a full window and water present
    do_reset();
    water_raw = 1; sample_valid = 1; temp_raw = 8'd200;
    repeat (8) step();
    check("pre_rst_water", water_ok, 1);
    check("pre_rst_over", over_temp, 1);
    check("pre_rst_filt", temp_filt, 200);
    #3 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    temp_raw = 8'd50;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_novalid", temp_valid, 0);
    end
    step();
    check("post_rst_valid", temp_valid, 1);
    check("post_rst_filt", temp_filt, 50);

    // Button bounce with water present: exactly one start pulse
    do_reset();
    sample_valid = 1; temp_raw = 8'd20; water_raw = 1; btn_raw = 0;
    repeat (8) step();
    check("bounce_water", water_ok, 1);
    pulses = 0;
    btn_raw = 1; step();
    btn_raw = 0; step();
    btn_raw = 1; step();
    check("bounce_nopulse", pulses, 0);
    repeat (10) step();
    check("bounce_one_pulse", pulses, 1);

    // Water removed: water_ok drops within 6 edges, press is discarded
    btn_raw = 0;
    repeat (8) step();
    water_raw = 0;
    repeat (6) step();
    check("dry_water_ok", water_ok, 0);
    repeat (2) step();
    pulses = 0;
    btn_raw = 1;
    repeat (10) step();
    check("dry_no_pulse", pulses, 0);
    btn_raw = 0;

    // Sample timeout: 63-cycle gaps tolerated, 64 latches a sticky fault
    do_reset();
    water_raw = 0; temp_raw = 8'd30;
    sample_valid = 1; step();
    for (int g = 0; g < 3; g++) begin
      sample_valid = 0;
      repeat (63) step();
      check("gap63_nofault", sensor_fault, 0);
      sample_valid = 1; step();
      check("gap63_sample_nofault", sensor_fault, 0);
    end
    sample_valid = 0;
    repeat (63) step();
    check("gap64_before", sensor_fault, 0);
    step();
    check("gap64_fault", sensor_fault, 1);
    sample_valid = 1;
    repeat (5) step();
    check("fault_sticky", sensor_fault, 1);

    // Randomized stimulus against the model, with a forced gap and a mid-run reset
    do_reset();
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 4) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 4) == 0) water_raw = ~water_raw;
      sample_valid = (i >= 1200 && i < 1280) ? 1'b0 : ($urandom_range(0, 2) == 0);
      temp_raw = 8'($urandom_range(0, 255));
      step();
      if (i == 1900) begin
        #2 rst_n = 1'b0;
        #1 check_all_zero("rand_rst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
